ripple_add_sequencer: RTL

- Multi-cycle wrapper stage that sits around the 64-bit ripple-carry adder. It feeds the adder and consumes what the adder produces.
- Accepts an operand pair over a valid/ready handshake and registers it onto the adder inputs. It holds those inputs stable for a programmable settle window so the carry chain can ripple through.
- After the window it samples sum/cout into output registers and presents them over a valid/ready handshake.
- Lets the purely combinational ripple adder be used safely in a clocked datapath without meeting single-cycle timing.

---
 rtl/ripple_add_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ripple_add_sequencer.sv
// ---------------------------------------------------------------------------
// ripple_add_sequencer
//
// Purpose:
//   Multi-cycle wrapper around a purely combinational ripple-carry adder.
//   An operand pair is accepted over a valid/ready handshake and registered
//   onto the adder inputs. Those inputs are held stable for SETTLE_CYCLES
//   clocks so the carry chain can ripple through. The adder's sum/carry is
//   then sampled into output registers and offered over a valid/ready
//   handshake. This lets the adder be used without meeting single-cycle
//   timing.
//
// Parameters:
//   WIDTH          operand/sum width (must match the adder instance)
//   SETTLE_CYCLES  cycles from operand register update to result sample, 1..255
//   CNT_W          settle counter width (must hold SETTLE_CYCLES)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   operand pair valid
//   in_ready   stage can accept operands (depends on state only)
//   in_a/in_b  operands
//   add_a/b    registered operands, drive the adder inputs
//   add_sum    adder sum output
//   add_cout   adder carry output
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_sum    registered sum
//   out_cout   registered carry (bit WIDTH of the unsigned result)
//   busy       high whenever the FSM is not idle
//   out_ovf    (only with RIPPLE_ADD_SEQUENCER_OVF_EN) registered signed
//              two's-complement overflow flag
//
// Build option:
//   RIPPLE_ADD_SEQUENCER_OVF_EN  adds the out_ovf port and its register.
// ---------------------------------------------------------------------------
module ripple_add_sequencer #(
  parameter int WIDTH         = 64,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef RIPPLE_ADD_SEQUENCER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic             accept;
  logic             sample;
  logic             drain;

`ifdef RIPPLE_ADD_SEQUENCER_OVF_EN
  // Signed overflow: operands share a sign but the sum's sign differs.
  function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                      input logic signed [WIDTH-1:0] b,
                                      input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction
`endif

  // in_ready must not depend on out_ready, so both flags decode state only.
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    sample  = 1'b0;
    drain   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // count==1 marks the last settle cycle: the carry chain has had
        // SETTLE_CYCLES full clocks since the operand registers updated.
        if (count_q == CNT_ONE) begin
          sample  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // out_valid is always high in HOLD, so out_ready alone completes it.
        if (out_ready) begin
          drain   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      add_a     <= '0;
      add_b     <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
`ifdef RIPPLE_ADD_SEQUENCER_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;

      // Operand capture stage: adder inputs change only here.
      if (accept) begin
        add_a   <= in_a;
        add_b   <= in_b;
        count_q <= SETTLE_INIT;
      end else if (state_q == SETTLE) begin
        count_q <= count_q - CNT_ONE;
      end

      // Result capture stage.
      if (sample) begin
        out_sum   <= add_sum;
        out_cout  <= add_cout;
        out_valid <= 1'b1;
`ifdef RIPPLE_ADD_SEQUENCER_OVF_EN
        out_ovf   <= signed_ovf(add_a, add_b, add_sum);
`endif
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
